// File: rtl/mem_writeback_pkg.sv
// Shared types for the writeback stage: widths, opcodes, the exec_out bus layout and FSM states.
package mem_writeback_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 10;
    localparam int REG_W  = 3;
    localparam int OPC_W  = 5;
    localparam int EXEC_W = OPC_W + REG_W + DATA_W + 2;
    localparam int CNT_W  = 16;

    localparam logic [OPC_W-1:0] OPC_NOP   = 5'h00;
    localparam logic [OPC_W-1:0] OPC_ADD   = 5'h01;
    localparam logic [OPC_W-1:0] OPC_SUB   = 5'h02;
    localparam logic [OPC_W-1:0] OPC_LOAD  = 5'h03;
    localparam logic [OPC_W-1:0] OPC_STORE = 5'h04;
    localparam logic [OPC_W-1:0] OPC_JUMP  = 5'h05;
    localparam logic [OPC_W-1:0] OPC_HALT  = 5'h1F;

    // Field order gives opcode [41:37], dest [36:34], result [33:2], read_memory [1], write_enable [0].
    typedef struct packed {
        logic [OPC_W-1:0]  opcode;
        logic [REG_W-1:0]  dest;
        logic [DATA_W-1:0] result;
        logic              read_memory;
        logic              write_enable;
    } exec_out_t;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOAD_WAIT = 2'd1,
        ST_HALTED    = 2'd2
    } wb_state_e;

    function automatic logic is_halt(input exec_out_t e);
        return e.opcode == OPC_HALT;
    endfunction

endpackage

// File: rtl/mem_writeback_if.sv
// Execute-to-writeback bus: instruction handshake, data-memory read port and register-file write port.
interface mem_writeback_if
    import mem_writeback_pkg::*;
();
    logic              exec_valid;
    exec_out_t         exec_in;
    logic              stall;
    logic              mem_rd_req;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic              mem_rd_valid;
    logic [DATA_W-1:0] mem_rd_data;
    logic              rf_we;
    logic [REG_W-1:0]  rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              halted;
    logic              mem_err;

    modport slave (
        input  exec_valid, exec_in, mem_rd_valid, mem_rd_data,
        output stall, mem_rd_req, mem_rd_addr, rf_we, rf_waddr, rf_wdata, halted, mem_err
    );

    modport master (
        output exec_valid, exec_in, mem_rd_valid, mem_rd_data,
        input  stall, mem_rd_req, mem_rd_addr, rf_we, rf_waddr, rf_wdata, halted, mem_err
    );
endinterface

// File: rtl/mem_writeback.sv
// Retires exec results to the register file and services loads; ALU writes land 1 cycle after accept, load data 1 cycle after mem_rd_valid.
// Backpressure: stall is combinational and high whenever a load is outstanding or the core has halted.
module mem_writeback
    import mem_writeback_pkg::*;
#(
    parameter int LOAD_TIMEOUT = 255
) (
    input  logic           clk,
    input  logic           rst_n,
    mem_writeback_if.slave bus
);

    localparam logic [CNT_W-1:0] TIMEOUT = CNT_W'(LOAD_TIMEOUT);

    wb_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic [REG_W-1:0]  dest_q, dest_d;
    logic              mem_rd_req_q, mem_rd_req_d;
    logic [ADDR_W-1:0] mem_rd_addr_q, mem_rd_addr_d;
    logic              rf_we_q, rf_we_d;
    logic [REG_W-1:0]  rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
    logic              halted_q, halted_d;
    logic              mem_err_q, mem_err_d;

    assign cnt_inc = cnt_q + CNT_W'(1);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        dest_d        = dest_q;
        mem_rd_req_d  = 1'b0;
        mem_rd_addr_d = mem_rd_addr_q;
        rf_we_d       = 1'b0;
        rf_waddr_d    = rf_waddr_q;
        rf_wdata_d    = rf_wdata_q;
        halted_d      = halted_q;
        mem_err_d     = mem_err_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.exec_valid) begin
                    if (is_halt(bus.exec_in)) begin
                        state_d  = ST_HALTED;
                        halted_d = 1'b1;
                    end else if (bus.exec_in.read_memory) begin
                        state_d       = ST_LOAD_WAIT;
                        cnt_d         = '0;
                        dest_d        = bus.exec_in.dest;
                        mem_rd_req_d  = 1'b1;
                        mem_rd_addr_d = bus.exec_in.result[ADDR_W-1:0];
                    end else if (bus.exec_in.write_enable) begin
                        rf_we_d    = 1'b1;
                        rf_waddr_d = bus.exec_in.dest;
                        rf_wdata_d = bus.exec_in.result;
                    end
                end
            end
            ST_LOAD_WAIT: begin
                // A response in the final wait cycle still wins over the timeout.
                if (bus.mem_rd_valid) begin
                    state_d    = ST_IDLE;
                    rf_we_d    = 1'b1;
                    rf_waddr_d = dest_q;
                    rf_wdata_d = bus.mem_rd_data;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == TIMEOUT) begin
                        state_d   = ST_IDLE;
                        mem_err_d = 1'b1;
                    end
                end
            end
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            dest_q        <= '0;
            mem_rd_req_q  <= 1'b0;
            mem_rd_addr_q <= '0;
            rf_we_q       <= 1'b0;
            rf_waddr_q    <= '0;
            rf_wdata_q    <= '0;
            halted_q      <= 1'b0;
            mem_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            dest_q        <= dest_d;
            mem_rd_req_q  <= mem_rd_req_d;
            mem_rd_addr_q <= mem_rd_addr_d;
            rf_we_q       <= rf_we_d;
            rf_waddr_q    <= rf_waddr_d;
            rf_wdata_q    <= rf_wdata_d;
            halted_q      <= halted_d;
            mem_err_q     <= mem_err_d;
        end
    end

    assign bus.stall       = (state_q != ST_IDLE);
    assign bus.mem_rd_req  = mem_rd_req_q;
    assign bus.mem_rd_addr = mem_rd_addr_q;
    assign bus.rf_we       = rf_we_q;
    assign bus.rf_waddr    = rf_waddr_q;
    assign bus.rf_wdata    = rf_wdata_q;
    assign bus.halted      = halted_q;
    assign bus.mem_err     = mem_err_q;

endmodule

// File: tb/tb_mem_writeback.sv
// Bench for mem_writeback: table of single-cycle retires, directed load/halt/reset sequences, random traffic vs a transaction model.
module tb_mem_writeback;
    import mem_writeback_pkg::*;

    localparam int TMO = 8;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    mem_writeback_if bus ();

    mem_writeback #(.LOAD_TIMEOUT(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [4:0]  opc;
        logic [2:0]  dest;
        logic [31:0] res;
        logic        we;
        logic        exp_we;
        logic [2:0]  exp_addr;
        logic [31:0] exp_data;
    } vec_t;

    typedef struct {
        int          cyc;
        logic [2:0]  dest;
        logic [31:0] data;
    } wr_t;

    vec_t        vecs [8];
    wr_t         exp_q [$];
    wr_t         w;
    logic [4:0]  opcs [6];
    exec_out_t   cur;
    logic        held;
    int          busy_until, req_cyc, rsp_cyc, err_from, k;
    logic [9:0]  req_addr;
    logic [31:0] rsp_data;

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
        end
    endtask

    function automatic exec_out_t mk(input logic [4:0] opc, input logic [2:0] d,
                                     input logic [31:0] r, input logic rm, input logic we);
        exec_out_t e;
        e.opcode       = opc;
        e.dest         = d;
        e.result       = r;
        e.read_memory  = rm;
        e.write_enable = we;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input exec_out_t e);
        bus.exec_valid = v;
        bus.exec_in    = e;
    endtask

    task automatic do_reset();
        rst_n            = 1'b0;
        bus.exec_valid   = 1'b0;
        bus.exec_in      = '0;
        bus.mem_rd_valid = 1'b0;
        bus.mem_rd_data  = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_stall"},  bus.stall,       0);
        check({tag, "_req"},    bus.mem_rd_req,  0);
        check({tag, "_addr"},   bus.mem_rd_addr, 0);
        check({tag, "_we"},     bus.rf_we,       0);
        check({tag, "_waddr"},  bus.rf_waddr,    0);
        check({tag, "_wdata"},  bus.rf_wdata,    0);
        check({tag, "_halted"}, bus.halted,      0);
        check({tag, "_err"},    bus.mem_err,     0);
    endtask

    initial begin
        vecs[0] = '{1'b1, OPC_ADD,   3'd3, 32'h0000_0007, 1'b1, 1'b1, 3'd3, 32'h0000_0007};
        vecs[1] = '{1'b1, OPC_SUB,   3'd0, 32'hFFFF_FFFF, 1'b1, 1'b1, 3'd0, 32'hFFFF_FFFF};
        vecs[2] = '{1'b1, OPC_NOP,   3'd5, 32'h0000_0123, 1'b0, 1'b0, 3'd0, 32'h0};
        vecs[3] = '{1'b1, OPC_STORE, 3'd6, 32'h0000_0055, 1'b0, 1'b0, 3'd0, 32'h0};
        vecs[4] = '{1'b1, OPC_ADD,   3'd7, 32'h8000_0000, 1'b1, 1'b1, 3'd7, 32'h8000_0000};
        vecs[5] = '{1'b1, OPC_JUMP,  3'd1, 32'h0000_0080, 1'b0, 1'b0, 3'd0, 32'h0};
        vecs[6] = '{1'b0, OPC_ADD,   3'd4, 32'h0BAD_0BAD, 1'b1, 1'b0, 3'd0, 32'h0};
        vecs[7] = '{1'b1, OPC_ADD,   3'd2, 32'h0000_0000, 1'b1, 1'b1, 3'd2, 32'h0000_0000};
        opcs    = '{OPC_NOP, OPC_ADD, OPC_SUB, OPC_STORE, OPC_JUMP, OPC_ADD};

        do_reset();
        check_all_zero("reset");

        // Back-to-back single-cycle retires from the table.
        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].v, mk(vecs[i].opc, vecs[i].dest, vecs[i].res, 1'b0, vecs[i].we));
            tick();
            check($sformatf("vec%0d_we", i), bus.rf_we, vecs[i].exp_we);
            if (vecs[i].exp_we) begin
                check($sformatf("vec%0d_waddr", i), bus.rf_waddr, vecs[i].exp_addr);
                check($sformatf("vec%0d_wdata", i), bus.rf_wdata, vecs[i].exp_data);
            end
            check($sformatf("vec%0d_stall", i), bus.stall, 0);
        end
        drive(1'b0, '0);
        tick();
        check("idle_we", bus.rf_we, 0);

        // Load with response four cycles after the request.
        drive(1'b1, mk(OPC_LOAD, 3'd5, 32'h0000_0012, 1'b1, 1'b1));
        tick();
        drive(1'b0, '0);
        check("ld_req", bus.mem_rd_req, 1);
        check("ld_addr", bus.mem_rd_addr, 10'h012);
        check("ld_stall0", bus.stall, 1);
        for (int i = 1; i <= 3; i++) begin
            tick();
            check($sformatf("ld_req_low%0d", i), bus.mem_rd_req, 0);
            check($sformatf("ld_stall%0d", i), bus.stall, 1);
            check($sformatf("ld_we_low%0d", i), bus.rf_we, 0);
        end
        bus.mem_rd_valid = 1'b1;
        bus.mem_rd_data  = 32'hDEAD_BEEF;
        tick();
        bus.mem_rd_valid = 1'b0;
        check("ld_we", bus.rf_we, 1);
        check("ld_waddr", bus.rf_waddr, 5);
        check("ld_wdata", bus.rf_wdata, 32'hDEAD_BEEF);
        check("ld_stall_done", bus.stall, 0);
        tick();
        check("ld_we_once", bus.rf_we, 0);

        // Load that never gets a response.
        drive(1'b1, mk(OPC_LOAD, 3'd2, 32'h0000_03FF, 1'b1, 1'b0));
        tick();
        drive(1'b0, '0);
        check("to_req", bus.mem_rd_req, 1);
        check("to_addr", bus.mem_rd_addr, 10'h3FF);
        for (int i = 0; i < TMO; i++) begin
            check($sformatf("to_stall%0d", i), bus.stall, 1);
            check($sformatf("to_err_low%0d", i), bus.mem_err, 0);
            tick();
        end
        check("to_err", bus.mem_err, 1);
        check("to_stall_clear", bus.stall, 0);
        check("to_no_we", bus.rf_we, 0);
        bus.mem_rd_valid = 1'b1;
        bus.mem_rd_data  = 32'h1111_2222;
        tick();
        bus.mem_rd_valid = 1'b0;
        check("stray_we", bus.rf_we, 0);
        check("stray_stall", bus.stall, 0);
        drive(1'b1, mk(OPC_ADD, 3'd6, 32'h0000_0066, 1'b0, 1'b1));
        tick();
        drive(1'b0, '0);
        check("post_to_we", bus.rf_we, 1);
        check("post_to_waddr", bus.rf_waddr, 6);
        check("post_to_wdata", bus.rf_wdata, 32'h66);
        check("err_sticky", bus.mem_err, 1);

        // ADD, SUB, LOAD, ADD offered every cycle; last ADD waits behind the load.
        do_reset();
        drive(1'b1, mk(OPC_ADD, 3'd1, 32'h11, 1'b0, 1'b1));
        tick();
        drive(1'b1, mk(OPC_SUB, 3'd2, 32'h22, 1'b0, 1'b1));
        check("b2b_add_we", bus.rf_we, 1);
        check("b2b_add_wdata", {bus.rf_waddr, bus.rf_wdata}, {3'd1, 32'h11});
        tick();
        drive(1'b1, mk(OPC_LOAD, 3'd3, 32'h40, 1'b1, 1'b1));
        check("b2b_sub_we", bus.rf_we, 1);
        check("b2b_sub_wdata", {bus.rf_waddr, bus.rf_wdata}, {3'd2, 32'h22});
        tick();
        drive(1'b1, mk(OPC_ADD, 3'd4, 32'h44, 1'b0, 1'b1));
        check("b2b_ld_req", {bus.mem_rd_req, bus.mem_rd_addr}, {1'b1, 10'h040});
        check("b2b_ld_stall", bus.stall, 1);
        check("b2b_ld_we", bus.rf_we, 0);
        tick();
        check("b2b_hold_stall", bus.stall, 1);
        check("b2b_hold_we", bus.rf_we, 0);
        tick();
        bus.mem_rd_valid = 1'b1;
        bus.mem_rd_data  = 32'h0000_CAFE;
        check("b2b_hold_stall2", bus.stall, 1);
        tick();
        bus.mem_rd_valid = 1'b0;
        check("b2b_ldata", {bus.rf_we, bus.rf_waddr, bus.rf_wdata}, {1'b1, 3'd3, 32'hCAFE});
        check("b2b_released", bus.stall, 0);
        tick();
        drive(1'b0, '0);
        check("b2b_add2", {bus.rf_we, bus.rf_waddr, bus.rf_wdata}, {1'b1, 3'd4, 32'h44});
        tick();
        check("b2b_end_we", bus.rf_we, 0);

        // HALT, then an ADD held on the bus.
        drive(1'b1, mk(OPC_HALT, 3'd7, 32'h77, 1'b0, 1'b1));
        tick();
        drive(1'b1, mk(OPC_ADD, 3'd5, 32'h55, 1'b0, 1'b1));
        for (int i = 0; i < 20; i++) begin
            check($sformatf("halt_halted%0d", i), bus.halted, 1);
            check($sformatf("halt_stall%0d", i), bus.stall, 1);
            check($sformatf("halt_we%0d", i), bus.rf_we, 0);
            tick();
        end
        rst_n = 1'b0;
        #1;
        check("halt_rst_halted", bus.halted, 0);
        check("halt_rst_stall", bus.stall, 0);
        do_reset();

        // Reset pulsed while waiting on a load, then a late response.
        drive(1'b1, mk(OPC_LOAD, 3'd6, 32'h155, 1'b1, 1'b1));
        tick();
        drive(1'b0, '0);
        check("rl_req", bus.mem_rd_req, 1);
        tick();
        rst_n = 1'b0;
        #1;
        check("rl_req_drop", bus.mem_rd_req, 0);
        check("rl_stall_drop", bus.stall, 0);
        tick();
        rst_n = 1'b1;
        bus.mem_rd_valid = 1'b1;
        bus.mem_rd_data  = 32'hBBBB_AAAA;
        tick();
        bus.mem_rd_valid = 1'b0;
        check_all_zero("rl_after");

        // Random traffic against a transaction-level model.
        do_reset();
        held       = 1'b0;
        busy_until = 0;
        req_cyc    = -1;
        rsp_cyc    = -1;
        err_from   = 1 << 30;
        req_addr   = '0;
        rsp_data   = '0;
        cur        = '0;
        for (int n = 0; n < 800; n++) begin
            tick();
            check("r_stall", bus.stall, n < busy_until);
            check("r_req", bus.mem_rd_req, n == req_cyc);
            if (n == req_cyc)
                check("r_addr", bus.mem_rd_addr, req_addr);
            check("r_err", bus.mem_err, n >= err_from);
            if (bus.rf_we) begin
                if (exp_q.size() == 0) begin
                    check("r_we_unexpected", bus.rf_we, 0);
                end else begin
                    w = exp_q.pop_front();
                    check("r_wr_cycle", n, w.cyc);
                    check("r_wr_dest", bus.rf_waddr, w.dest);
                    check("r_wr_data", bus.rf_wdata, w.data);
                end
            end else if (exp_q.size() > 0 && exp_q[0].cyc <= n) begin
                check("r_we_missing", bus.rf_we, 1);
                void'(exp_q.pop_front());
            end

            bus.mem_rd_valid = (n == rsp_cyc) || (n >= busy_until && $urandom_range(0, 9) == 0);
            bus.mem_rd_data  = (n == rsp_cyc) ? rsp_data : $urandom;

            if (!held) begin
                if (n < 760 && $urandom_range(0, 4) != 0) begin
                    k = $urandom_range(0, 7);
                    if (k >= 6)
                        cur = mk(OPC_LOAD, 3'($urandom), $urandom, 1'b1, 1'($urandom));
                    else
                        cur = mk(opcs[k], 3'($urandom), $urandom, 1'b0, 1'($urandom));
                    drive(1'b1, cur);
                    held = 1'b1;
                end else begin
                    drive(1'b0, mk(5'($urandom), 3'($urandom), $urandom, 1'($urandom), 1'($urandom)));
                end
            end
            if (held && !bus.stall) begin
                held = 1'b0;
                if (cur.read_memory) begin
                    k        = $urandom_range(0, 9);
                    req_cyc  = n + 1;
                    req_addr = cur.result[9:0];
                    if (k < TMO) begin
                        rsp_cyc    = n + 1 + k;
                        rsp_data   = $urandom;
                        busy_until = n + 2 + k;
                        exp_q.push_back(wr_t'{n + 2 + k, cur.dest, rsp_data});
                    end else begin
                        busy_until = n + 1 + TMO;
                        if (n + 1 + TMO < err_from)
                            err_from = n + 1 + TMO;
                    end
                end else if (cur.write_enable) begin
                    exp_q.push_back(wr_t'{n + 1, cur.dest, cur.result});
                end
            end
        end
        check("r_drain", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
